// File: rtl/spi_peripheral_if.sv
// Bundles the SPI wires and the host-side transmit/receive signals of spi_peripheral.
// The slave modport is the peripheral's view; master is the initiator/host view.
interface spi_peripheral_if #(
    parameter int DWIDTH = 8
);
    logic              sclk;
    logic              cs;
    logic              mosi;
    logic              miso;
    logic              wr;
    logic [DWIDTH-1:0] din;
    logic [DWIDTH-1:0] dout;
    logic              done;
    logic              tx_full;
    logic              busy;

    modport slave (
        input  sclk, cs, mosi, wr, din,
        output miso, dout, done, tx_full, busy
    );

    modport master (
        output sclk, cs, mosi, wr, din,
        input  miso, dout, done, tx_full, busy
    );
endinterface

// File: rtl/spi_peripheral.sv
// SPI mode-0, MSB-first peripheral with a one-word transmit buffer.
// sclk/cs/mosi are oversampled by clk through two-flop synchronizers.
module spi_peripheral #(
    parameter int DWIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    spi_peripheral_if.slave bus
);
    localparam int CW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DWIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state;
    logic              sclk_p1, sclk_p2, sclk_p3;
    logic              cs_p1, cs_p2, cs_p3;
    logic              mosi_p1, mosi_p2;
    logic              sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic              accept_wr;
    logic [CW-1:0]     bit_cnt;
    logic [DWIDTH-1:0] tx_sr, rx_sr, tx_buf, dout_r;
    logic [DWIDTH-1:0] load_word, rx_next;
    logic              word_end;
    logic              miso_r, done_r, tx_full_r, busy_r;

    // Stage 1-2 synchronize; stage 3 is only the delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            sclk_p3 <= 1'b0;
            cs_p1   <= 1'b1;
            cs_p2   <= 1'b1;
            cs_p3   <= 1'b1;
            mosi_p1 <= 1'b0;
            mosi_p2 <= 1'b0;
        end else begin
            sclk_p1 <= bus.sclk;
            sclk_p2 <= sclk_p1;
            sclk_p3 <= sclk_p2;
            cs_p1   <= bus.cs;
            cs_p2   <= cs_p1;
            cs_p3   <= cs_p2;
            mosi_p1 <= bus.mosi;
            mosi_p2 <= mosi_p1;
        end
    end

    assign sclk_rise = sclk_p2 & ~sclk_p3;
    assign sclk_fall = ~sclk_p2 & sclk_p3;
    assign cs_fall   = ~cs_p2 & cs_p3;
    assign cs_rise   = cs_p2 & ~cs_p3;
    assign accept_wr = bus.wr & ~tx_full_r;
    assign load_word = tx_full_r ? tx_buf : '0;
    assign rx_next   = {rx_sr[DWIDTH-2:0], mosi_p2};

    // A buffer load in the same cycle as a write takes the old (possibly empty) buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            tx_buf    <= '0;
            dout_r    <= '0;
            word_end  <= 1'b0;
            miso_r    <= 1'b0;
            done_r    <= 1'b0;
            tx_full_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            tx_full_r <= tx_full_r | accept_wr;
            if (accept_wr) begin
                tx_buf <= bus.din;
            end
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state     <= SHIFT;
                        busy_r    <= 1'b1;
                        bit_cnt   <= '0;
                        word_end  <= 1'b0;
                        tx_sr     <= load_word;
                        miso_r    <= load_word[DWIDTH-1];
                        tx_full_r <= accept_wr;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state    <= IDLE;
                        busy_r   <= 1'b0;
                        bit_cnt  <= '0;
                        word_end <= 1'b0;
                        miso_r   <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_sr <= rx_next;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt  <= '0;
                            dout_r   <= rx_next;
                            done_r   <= 1'b1;
                            word_end <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end else if (sclk_fall) begin
                        // The fall closing a word starts the next one from the buffer.
                        if (word_end) begin
                            word_end  <= 1'b0;
                            tx_sr     <= load_word;
                            miso_r    <= load_word[DWIDTH-1];
                            tx_full_r <= accept_wr;
                        end else begin
                            tx_sr  <= {tx_sr[DWIDTH-2:0], 1'b0};
                            miso_r <= tx_sr[DWIDTH-2];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.miso    = miso_r;
    assign bus.dout    = dout_r;
    assign bus.done    = done_r;
    assign bus.tx_full = tx_full_r;
    assign bus.busy    = busy_r;
endmodule
